// File: rtl/audio_dac_serializer_pkg.sv
// Shared types and defaults for the I2S DAC serializer slice.
package audio_dac_pkg;
  localparam int   DEF_DATA_W     = 16;
  localparam int   DEF_FIFO_DEPTH = 8;
  localparam logic LRCK_LEFT      = 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_SHIFT, S_PAD} state_t;
endpackage

// File: rtl/audio_dac_serializer_if.sv
// Stereo PCM frame stream (valid/ready) feeding the DAC serializer.
interface audio_dac_serializer_if
  import audio_dac_pkg::*;
  #(parameter int DATA_W = DEF_DATA_W);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO; head word is read straight from the register array.
module audio_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer slaved to codec BCLK/DACLRCK, fed from a frame FIFO.
// Optional AUDIO_DAC_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
//
// state   | meaning
// S_IDLE  | disabled, DACDAT held low
// S_SYNC  | enabled, waiting for the first left-channel boundary
// S_SHIFT | shifting the current word out MSB-first
// S_PAD   | word finished, zeros until the next boundary
module audio_dac_serializer
  import audio_dac_pkg::*;
  #(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        enable,
  audio_dac_serializer_if.slave       s,
  input  logic                        BCLK,
  input  logic                        DACLRCK,
  output logic                        DACDAT,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  output logic [15:0]                 underrun_cnt,
`endif
  output logic                        underrun
);
  localparam int BW = $clog2(DATA_W);

  logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync;
  logic                   bclk_d, rise_q, fall_q;
  logic                   lrck_cur, lrck_prev, boundary;
  state_t                 state, state_nxt;
  logic [DATA_W-1:0]      shreg, hold, word_in;
  logic [BW-1:0]          bitcnt;
  logic                   dat_q, underrun_q;
  logic                   load_left, load_right, shift, pad;
  logic                   pop, underrun_evt;
  logic [2*DATA_W-1:0]    head;
  logic                   fifo_full, fifo_empty;

  audio_frame_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .push          (s.s_valid),
    .wr_data       ({s.s_left, s.s_right}),
    .pop           (pop),
    .rd_data       (head),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .level         (fifo_level)
  );

  assign s.s_ready = !fifo_full;

  // Edge strobes are registered so DACDAT moves SYNC_STAGES+2 clocks after the pin fall.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_d    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      lrck_cur  <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], DACLRCK};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      rise_q    <= bclk_sync[SYNC_STAGES-1] & ~bclk_d;
      fall_q    <= ~bclk_sync[SYNC_STAGES-1] & bclk_d;
      if (rise_q) lrck_cur  <= lrck_sync[SYNC_STAGES-1];
      if (fall_q) lrck_prev <= lrck_cur;
    end
  end

  assign boundary = (lrck_cur != lrck_prev);

  always_comb begin
    state_nxt  = state;
    load_left  = 1'b0;
    load_right = 1'b0;
    shift      = 1'b0;
    pad        = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_SYNC;
        S_SYNC: begin
          if (fall_q && boundary && (lrck_cur == LRCK_LEFT)) begin
            load_left = 1'b1;
            state_nxt = S_SHIFT;
          end
        end
        S_SHIFT, S_PAD: begin
          if (fall_q) begin
            if (boundary) begin
              load_left  = (lrck_cur == LRCK_LEFT);
              load_right = (lrck_cur != LRCK_LEFT);
              state_nxt  = S_SHIFT;
            end else if ((state == S_SHIFT) && (bitcnt != '0)) begin
              shift = 1'b1;
              if (bitcnt == BW'(1)) state_nxt = S_PAD;
            end else begin
              pad       = 1'b1;
              state_nxt = S_PAD;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign pop          = load_left && !fifo_empty;
  assign underrun_evt = load_left && fifo_empty;
  assign word_in      = load_left ? (fifo_empty ? '0 : head[2*DATA_W-1:DATA_W]) : hold;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      hold       <= '0;
      bitcnt     <= '0;
      dat_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_left || load_right) begin
        dat_q  <= word_in[DATA_W-1];
        shreg  <= {word_in[DATA_W-2:0], 1'b0};
        bitcnt <= BW'(DATA_W-1);
        if (load_left) hold <= fifo_empty ? '0 : head[DATA_W-1:0];
      end else if (shift) begin
        dat_q  <= shreg[DATA_W-1];
        shreg  <= {shreg[DATA_W-2:0], 1'b0};
        bitcnt <= bitcnt - 1'b1;
      end else if (pad || (state == S_IDLE) || (state == S_SYNC)) begin
        dat_q <= 1'b0;
      end
      if (!enable)           underrun_q <= 1'b0;
      else if (underrun_evt) underrun_q <= 1'b1;
    end
  end

  // Output gated by enable so disabling silences the pin without waiting a clock.
  assign DACDAT   = dat_q & enable;
  assign underrun = underrun_q;

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                          ur_cnt <= '0;
    else if (!enable)                            ur_cnt <= '0;
    else if (underrun_evt && (ur_cnt != 16'hFFFF)) ur_cnt <= ur_cnt + 1'b1;
  end

  assign underrun_cnt = ur_cnt;
`endif
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: drives BCLK/LRCK slots and checks DACDAT against an I2S slot model.
module tb_audio_dac_serializer;
  localparam int DW = 16;
  localparam int DEPTH = 8;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic enable = 1'b0;
  logic BCLK = 1'b1;
  logic DACLRCK = 1'b0;
  logic DACDAT;
  logic [3:0] fifo_level;
  logic underrun;
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  audio_dac_serializer_if #(.DATA_W(DW)) sif ();

  audio_dac_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .enable        (enable),
    .s             (sif),
    .BCLK          (BCLK),
    .DACLRCK       (DACLRCK),
    .DACDAT        (DACDAT),
    .fifo_level    (fifo_level),
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    .underrun_cnt  (underrun_cnt),
`endif
    .underrun      (underrun)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int failures = 0;

  // reference model: frame queue, expected serial bits, channel hold, sticky flags
  logic [2*DW-1:0] mq[$];
  bit              exp_q[$];
  bit              m_synced, m_ur;
  logic [DW-1:0]   m_hold;
  int              m_urcnt;
  logic [2*DW-1:0] pend_frame;
  bit              pend, last_ok;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk_clk);
    if (pend && last_ok) begin
      sif.s_valid = 1'b0;
      pend = 1'b0;
      mq.push_back(pend_frame);
    end
    last_ok = sif.s_valid && sif.s_ready;
  endtask

  task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    check_val("push_ready", sif.s_ready, 32'(mq.size() < DEPTH));
    sif.s_left = l;
    sif.s_right = r;
    sif.s_valid = 1'b1;
    tick();
    sif.s_valid = 1'b0;
    mq.push_back({l, r});
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    #1;
    check_val("rst_dacdat", DACDAT, 0);
    check_val("rst_ready", sif.s_ready, 1);
    check_val("rst_level", fifo_level, 0);
    check_val("rst_underrun", underrun, 0);
    repeat (3) tick();
    reset_reset_n = 1'b1;
    mq.delete();
    m_synced = 1'b0;
    m_ur = 1'b0;
    m_urcnt = 0;
    foreach (exp_q[k]) exp_q[k] = 1'b0;
  endtask

  // One BCLK period: sample DACDAT just before the fall, then fall (LRCK moves) and rise.
  task automatic bclk_cycle(input bit lr, input bit lat_chk);
    bit e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
    check_val("dacdat", DACDAT, 32'(e));
    BCLK = 1'b0;
    DACLRCK = lr;
    if (lat_chk) begin
      repeat (3) tick();
      check_val("lat_hold", DACDAT, 32'(e));
      tick();
      check_val("lat_new", DACDAT, 32'(exp_q[0]));
    end else begin
      repeat (4) tick();
    end
    BCLK = 1'b1;
    repeat (4) tick();
  endtask

  // A channel slot of n BCLKs carries the word's first n bits, delayed one BCLK after the LRCK edge.
  task automatic run_slot(input bit lr, input int n, input int lat_j, input int rst_j);
    logic [DW-1:0]   w;
    logic [2*DW-1:0] f;
    if (!enable) begin
      m_synced = 1'b0;
      w = '0;
    end else if (lr == 1'b0) begin
      m_synced = 1'b1;
      if (mq.size() != 0) begin
        f = mq.pop_front();
        w = f[2*DW-1:DW];
        m_hold = f[DW-1:0];
      end else begin
        w = '0;
        m_hold = '0;
        m_ur = 1'b1;
        if (m_urcnt < 65535) m_urcnt++;
      end
    end else begin
      w = m_synced ? m_hold : '0;
    end
    for (int j = 0; j < n; j++) begin
      if (j == rst_j) do_reset();
      bclk_cycle(lr, j == lat_j);
      if (j == 0)
        for (int i = 0; i < n; i++) exp_q.push_back((i < DW) ? w[DW-1-i] : 1'b0);
      if (j == n / 2) begin
        check_val("level", fifo_level, mq.size());
        check_val("underrun", underrun, 32'(m_ur));
        check_val("s_ready", sif.s_ready, 32'(mq.size() < DEPTH));
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        check_val("ur_cnt", underrun_cnt, m_urcnt);
`endif
      end
    end
  endtask

  task automatic disable_phase();
    enable = 1'b0;
    #1;
    check_val("off_dacdat", DACDAT, 0);
    tick();
    check_val("off_underrun", underrun, 0);
    check_val("off_level", fifo_level, mq.size());
    m_ur = 1'b0;
    m_urcnt = 0;
    m_synced = 1'b0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_left = '0;
    sif.s_right = '0;
    pend = 1'b0;
    last_ok = 1'b0;
    m_synced = 1'b0;
    m_ur = 1'b0;
    m_hold = '0;
    m_urcnt = 0;
    repeat (3) tick();
    check_val("reset_dacdat", DACDAT, 0);
    check_val("reset_ready", sif.s_ready, 1);
    check_val("reset_level", fifo_level, 0);
    check_val("reset_underrun", underrun, 0);
    reset_reset_n = 1'b1;
    tick();
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    run_slot(1, 32, -1, -1);
    run_slot(0, 32, -1, -1);

    // basic frame
    push_frame(16'hA5C3, 16'h1234);
    enable = 1'b1;
    run_slot(1, 32, -1, -1);
    check_val("basic_level_pre", fifo_level, 1);
    run_slot(0, 32, 1, -1);
    run_slot(1, 32, -1, -1);
    run_slot(0, 32, -1, -1);
    run_slot(1, 32, -1, -1);
    disable_phase();

    // underrun then resume
    enable = 1'b1;
    run_slot(1, 32, -1, -1);
    run_slot(0, 32, -1, -1);
    run_slot(1, 32, -1, -1);
    for (int k = 0; k < 8; k++) push_frame(DW'($urandom), DW'($urandom));
    for (int k = 0; k < 8; k++) begin
      run_slot(0, 32, -1, -1);
      run_slot(1, 32, -1, -1);
    end
    check_val("ur_sticky", underrun, 1);
    disable_phase();

    // full FIFO with a ninth frame held off
    for (int k = 0; k < 8; k++) push_frame(DW'($urandom), DW'($urandom));
    check_val("full_ready", sif.s_ready, 0);
    check_val("full_level", fifo_level, 8);
    pend_frame = {DW'($urandom), DW'($urandom)};
    sif.s_left = pend_frame[2*DW-1:DW];
    sif.s_right = pend_frame[DW-1:0];
    sif.s_valid = 1'b1;
    last_ok = 1'b0;
    pend = 1'b1;
    repeat (20) tick();
    check_val("held9", 32'(pend), 1);
    check_val("held9_level", fifo_level, 8);
    enable = 1'b1;
    run_slot(1, 32, -1, -1);
    run_slot(0, 32, -1, -1);
    check_val("acc9", 32'(pend), 0);
    for (int k = 0; k < 9; k++) begin
      run_slot(1, 32, -1, -1);
      run_slot(0, 32, -1, -1);
    end
    disable_phase();

    // short slots truncate the word
    push_frame(16'hFFFF, DW'($urandom));
    push_frame(DW'($urandom), 16'hFFFF);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_slot(1, 12, -1, -1);
      run_slot(0, 12, -1, -1);
    end
    run_slot(1, 12, -1, -1);
    disable_phase();

    // randomized slot lengths and traffic
    for (int it = 0; it < 4; it++) begin
      int nf;
      nf = int'($urandom_range(1, 5));
      for (int k = 0; k < nf; k++) push_frame(DW'($urandom), DW'($urandom));
      enable = 1'b1;
      for (int p = 0; p < nf + 1; p++) begin
        run_slot(1, int'($urandom_range(10, 32)), -1, -1);
        if (mq.size() < DEPTH && $urandom_range(0, 1) == 1)
          push_frame(DW'($urandom), DW'($urandom));
        run_slot(0, int'($urandom_range(10, 32)), -1, -1);
      end
      disable_phase();
    end

    // async reset in mid-shift
    push_frame(DW'($urandom), DW'($urandom));
    push_frame(DW'($urandom), DW'($urandom));
    enable = 1'b1;
    run_slot(1, 32, -1, -1);
    run_slot(0, 32, -1, 6);
    run_slot(1, 32, -1, -1);
    run_slot(0, 32, -1, -1);
    run_slot(1, 32, -1, -1);
    disable_phase();

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    check_val("cnt_clear", underrun_cnt, 0);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      run_slot(1, 32, -1, -1);
      run_slot(0, 32, -1, -1);
    end
    check_val("cnt_five", underrun_cnt, 5);
    force dut.ur_cnt = 16'hFFFF;
    tick();
    release dut.ur_cnt;
    m_urcnt = 65535;
    run_slot(1, 32, -1, -1);
    run_slot(0, 32, -1, -1);
    check_val("cnt_sat", underrun_cnt, 32'hFFFF);
    disable_phase();
    check_val("cnt_off", underrun_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
